// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter
//   Shares one single-port synchronous VRAM between VGA scanout and a CPU bus port.
//   Scanout prefetches one 24-bit word (8 pixels x 3 bpp) two cycles before the word is
//   displayed and always wins the memory; the CPU uses any cycle scanout does not need,
//   through a two-state req/ready handshake (at most one transaction every 2 cycles).
//
// Ports
//   clk25175KHz   pixel clock; all state on its rising edge
//   reset         synchronous, active-high
//   hcount/vcount current column/line from the timing generator
//   red/green/blue pixel colour, forced to 0 outside the active window
//   mem_addr/mem_we/mem_wdata  VRAM command (combinational, valid in the issue cycle)
//   mem_rdata     VRAM read data, valid the cycle after issue
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held stable until cpu_ready
//   cpu_ready     one-cycle completion pulse; cpu_rdata valid with it
//   cpu_stall_cnt cycles a CPU request was blocked by a scanout fetch
//
// Configuration
//   VGA_ARB_STALL_CNT_EN  when defined, cpu_stall_cnt is a saturating counter;
//                         otherwise it is tied to 0.

module vga_vram_arbiter #(
    parameter int unsigned H_START = 144,
    parameter int unsigned V_START = 35,
    parameter int unsigned H_PIX   = 640,
    parameter int unsigned V_PIX   = 480,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic              clk25175KHz,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic              red,
    output logic              green,
    output logic              blue,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [23:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [23:0]       cpu_rdata,
    output logic [15:0]       cpu_stall_cnt
);

    localparam int unsigned WPL = H_PIX / 8;

    localparam logic [9:0] H_ACT_FIRST = 10'(H_START);
    localparam logic [9:0] H_ACT_END   = 10'(H_START + H_PIX);
    localparam logic [9:0] SLOT_FIRST  = 10'(H_START - 2);
    localparam logic [9:0] SLOT_END    = 10'(H_START + H_PIX - 2);
    localparam logic [9:0] V_ACT_FIRST = 10'(V_START);
    localparam logic [9:0] V_ACT_END   = 10'(V_START + V_PIX);

    typedef enum logic {StIdle, StAck} state_e;

    state_e      state_q, state_d;
    logic        cpu_issue;
    logic        load_q;
    logic [23:0] pix_q;

    logic              v_active, h_active, slot;
    logic [9:0]        slot_offs, line_idx;
    logic [ADDR_W-1:0] scan_addr;

    // Slot timing: word n is fetched at H_START+8n-2, lands on mem_rdata at
    // H_START+8n-1 and is in the shift register for H_START+8n..H_START+8n+7.
    always_comb begin
        v_active  = (vcount >= V_ACT_FIRST) && (vcount < V_ACT_END);
        h_active  = (hcount >= H_ACT_FIRST) && (hcount < H_ACT_END);
        slot_offs = hcount - SLOT_FIRST;
        line_idx  = vcount - V_ACT_FIRST;
        slot      = v_active && (hcount >= SLOT_FIRST) && (hcount < SLOT_END) &&
                    (slot_offs[2:0] == 3'd0);
        scan_addr = ADDR_W'(line_idx) * ADDR_W'(WPL) + ADDR_W'(slot_offs[9:3]);
    end

    // CPU handshake FSM
    always_comb begin
        state_d   = state_q;
        cpu_issue = 1'b0;
        case (state_q)
            StIdle: begin
                // A colliding scanout slot simply defers the request by a cycle.
                if (cpu_req && !slot) begin
                    cpu_issue = 1'b1;
                    state_d   = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk25175KHz) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory command mux and CPU response
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (slot) begin
            mem_addr = scan_addr;
        end else if (cpu_issue) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we && !reset;
            mem_wdata = cpu_wdata;
        end
        // Gated by reset so an aborted transaction never signals completion.
        cpu_ready = (state_q == StAck) && !reset;
        cpu_rdata = cpu_ready ? mem_rdata : '0;
        {red, green, blue} = (h_active && v_active) ? pix_q[2:0] : 3'b000;
    end

    // Pixel shift register: load the fetched word, otherwise shift one pixel out per clock.
    always_ff @(posedge clk25175KHz) begin
        if (reset) begin
            load_q <= 1'b0;
            pix_q  <= '0;
        end else begin
            load_q <= slot;
            if (load_q) begin
                pix_q <= mem_rdata;
            end else begin
                pix_q <= pix_q >> 3;
            end
        end
    end

`ifdef VGA_ARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk25175KHz) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && cpu_req && slot && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign cpu_stall_cnt = stall_q;
`else
    assign cpu_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount;
    logic        red, green, blue;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [23:0] mem_wdata, mem_rdata;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_ready;
    logic [23:0] cpu_rdata;
    logic [15:0] cpu_stall_cnt;

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [23:0] pre_data;
    logic [23:0] vram [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_vram_arbiter dut (
        .clk25175KHz  (clk),
        .reset        (reset),
        .hcount       (hcount),
        .vcount       (vcount),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall_cnt(cpu_stall_cnt)
    );

    // Single-port synchronous VRAM model with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            vram[pre_addr] <= pre_data;
        end else if (mem_we) begin
            vram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= vram[mem_addr];
    end

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs [12];

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [23:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        next();
        pre_we   = 1'b0;
    endtask

    // Fetch the all-ones word at slot n=79 so the shift register is non-zero.
    task automatic load_ones();
        hcount = 10'd774;
        vcount = 10'd35;
        next();
        hcount = 10'd775;
        next();
    endtask

    logic [15:0] exp_stall;
    int          bad;

    initial begin
        vecs[0]  = '{h: 10'd142, v: 10'd35,  addr: 16'd0};
        vecs[1]  = '{h: 10'd150, v: 10'd35,  addr: 16'd1};
        vecs[2]  = '{h: 10'd774, v: 10'd36,  addr: 16'd159};
        vecs[3]  = '{h: 10'd782, v: 10'd36,  addr: 16'd0};
        vecs[4]  = '{h: 10'd143, v: 10'd35,  addr: 16'd0};
        vecs[5]  = '{h: 10'd142, v: 10'd34,  addr: 16'd0};
        vecs[6]  = '{h: 10'd142, v: 10'd514, addr: 16'd38320};
        vecs[7]  = '{h: 10'd142, v: 10'd515, addr: 16'd0};
        vecs[8]  = '{h: 10'd134, v: 10'd35,  addr: 16'd0};
        vecs[9]  = '{h: 10'd0,   v: 10'd0,   addr: 16'd0};
        vecs[10] = '{h: 10'd146, v: 10'd100, addr: 16'd0};
        vecs[11] = '{h: 10'd158, v: 10'd40,  addr: 16'd402};

`ifdef VGA_ARB_STALL_CNT_EN
        exp_stall = 16'd1;
`else
        exp_stall = 16'd0;
`endif

        reset = 1'b1; hcount = '0; vcount = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        next();
        next();
        hcount = 10'd144;
        vcount = 10'd35;
        #2;
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_stall", 32'(cpu_stall_cnt), 32'd0);

        preload(16'd0, 24'o76543210);
        preload(16'd1, 24'd0);
        preload(16'd5, 24'd0);
        preload(16'd6, 24'd0);
        preload(16'd79, 24'hFFFFFF);
        reset = 1'b0; hcount = '0; vcount = '0;
        next();

        // Scanout addressing vectors
        for (int i = 0; i < 12; i++) begin
            hcount = vecs[i].h;
            vcount = vecs[i].v;
            #2;
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'd0);
            next();
        end

        // First word of a line shifted out pixel by pixel
        hcount = 10'd142; vcount = 10'd35;
        #2;
        chk("w0_addr", 32'(mem_addr), 32'd0);
        next();
        hcount = 10'd143;
        next();
        for (int k = 0; k < 8; k++) begin
            hcount = 10'(144 + k);
            #2;
            chk($sformatf("w0_rgb%0d", k), 32'({red, green, blue}), 32'(k));
            next();
        end

        // Blanking must mask a non-empty shift register
        load_ones();
        hcount = 10'd776;
        #2;
        chk("ones_rgb", 32'({red, green, blue}), 32'd7);
        next();
        load_ones();
        hcount = 10'd784;
        #2;
        chk("h_end_rgb", 32'({red, green, blue}), 32'd0);
        next();
        load_ones();
        hcount = 10'd144; vcount = 10'd515;
        #2;
        chk("v_end_rgb", 32'({red, green, blue}), 32'd0);
        next();

        bad = 0;
        for (int h = 0; h < 800; h++) begin
            hcount = 10'(h);
            #2;
            if (mem_addr != 16'd0 || mem_we) bad++;
            next();
        end
        chk("v_end_noslot", 32'(bad), 32'd0);

        // CPU write then read in blanking
        hcount = 10'd0; vcount = 10'd0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd5; cpu_wdata = 24'hABCDEF;
        #2;
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'd5);
        chk("wr_wdata", 32'(mem_wdata), 32'hABCDEF);
        chk("wr_ready0", 32'(cpu_ready), 32'd0);
        next();
        #2;
        chk("wr_ready1", 32'(cpu_ready), 32'd1);
        chk("wr_ack_we", 32'(mem_we), 32'd0);
        chk("wr_ack_addr", 32'(mem_addr), 32'd0);
        next();
        cpu_req = 1'b0; cpu_we = 1'b0;
        #2;
        chk("wr_ready2", 32'(cpu_ready), 32'd0);
        next();
        cpu_req = 1'b1;
        #2;
        chk("rd_addr", 32'(mem_addr), 32'd5);
        chk("rd_we", 32'(mem_we), 32'd0);
        next();
        #2;
        chk("rd_ready", 32'(cpu_ready), 32'd1);
        chk("rd_data", 32'(cpu_rdata), 32'hABCDEF);
        next();
        cpu_req = 1'b0;
        next();

        // Read colliding with the first slot of a line
        hcount = 10'd142; vcount = 10'd35; cpu_req = 1'b1; cpu_addr = 16'd5;
        #2;
        chk("col_slot_addr", 32'(mem_addr), 32'd0);
        chk("col_ready0", 32'(cpu_ready), 32'd0);
        next();
        hcount = 10'd143;
        #2;
        chk("col_issue_addr", 32'(mem_addr), 32'd5);
        next();
        hcount = 10'd144;
        #2;
        chk("col_ready", 32'(cpu_ready), 32'd1);
        chk("col_rdata", 32'(cpu_rdata), 32'hABCDEF);
        chk("col_stall", 32'(cpu_stall_cnt), 32'(exp_stall));
        next();
        cpu_req = 1'b0; hcount = 10'd145;
        #2;
        chk("col_rgb", 32'({red, green, blue}), 32'd1);
        next();

        // Reset in the ACK cycle of a read
        hcount = 10'd142; cpu_req = 1'b1;
        next();
        hcount = 10'd143;
        next();
        hcount = 10'd144; reset = 1'b1;
        #2;
        chk("abort_ready", 32'(cpu_ready), 32'd0);
        chk("abort_rdata", 32'(cpu_rdata), 32'd0);
        next();
        reset = 1'b0; cpu_req = 1'b0; hcount = 10'd145;
        #2;
        chk("abort_rgb", 32'({red, green, blue}), 32'd0);
        chk("abort_ready2", 32'(cpu_ready), 32'd0);
        chk("abort_stall", 32'(cpu_stall_cnt), 32'd0);
        next();

        // Write presented during reset is suppressed
        hcount = 10'd0; vcount = 10'd0; reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd6; cpu_wdata = 24'h123456;
        #2;
        chk("rst_wr_we", 32'(mem_we), 32'd0);
        next();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        next();
        cpu_req = 1'b1;
        #2;
        chk("rst_rd_addr", 32'(mem_addr), 32'd6);
        next();
        #2;
        chk("rst_rd_ready", 32'(cpu_ready), 32'd1);
        chk("rst_rd_data", 32'(cpu_rdata), 32'd0);
        next();
        cpu_req = 1'b0;
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
